// File: rtl/exwb_skid_stage.sv
// exwb_skid_stage: EX->WB pipeline stage built as a 2-entry skid buffer.
// Valid/ready on both sides, flush, and a write-back data mux on the head entry.
// All state updates happen on the falling edge of clk. The reset is asynchronous
// and active-low.
// Optional feature: define EXWB_STALL_CNT_EN to add a saturating stall counter
// (output stall_cnt).
module exwb_skid_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 6,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_mem,
  output logic [DATA_W-1:0] out_alu,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_wbdata,
  output logic              out_regwe,
  output logic [1:0]        occupancy
`ifdef EXWB_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  // ctrl bit positions used locally
  localparam int C_MEM2REG = 2;
  localparam int C_REGWRT  = 3;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] mem;
    logic [DATA_W-1:0] alu;
    logic [RD_W-1:0]   rd;
  } entry_t;

  entry_t head_q, head_d, skid_q, skid_d, in_ent;
  logic   head_valid_q, head_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   push, pop;

  // in_ready comes straight from a flop: the stage is ready whenever the skid slot is free
  assign in_ready  = ~skid_valid_q;
  assign out_valid = head_valid_q;
  assign push      = in_valid & in_ready;
  assign pop       = head_valid_q & out_ready;
  assign in_ent    = '{ctrl: in_ctrl, mem: in_mem, alu: in_alu, rd: in_rd};

  // Next-state of the two slots; the skid slot is only filled behind a stalled head
  always_comb begin
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!head_valid_q) begin
      if (push) begin
        head_d       = in_ent;
        head_valid_d = 1'b1;
      end
    end else if (!skid_valid_q) begin
      if (push && pop) begin
        head_d = in_ent;
      end else if (push) begin
        skid_d       = in_ent;
        skid_valid_d = 1'b1;
      end else if (pop) begin
        head_valid_d = 1'b0;
      end
    end else if (pop) begin
      head_d       = skid_q;
      skid_valid_d = 1'b0;
    end
  end

  // Slot registers, updated on the falling edge
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_ctrl   = head_q.ctrl;
  assign out_mem    = head_q.mem;
  assign out_alu    = head_q.alu;
  assign out_rd     = head_q.rd;
  assign out_wbdata = head_q.ctrl[C_MEM2REG] ? head_q.mem : head_q.alu;
  assign out_regwe  = head_valid_q & head_q.ctrl[C_REGWRT];
  assign occupancy  = {1'b0, head_valid_q} + {1'b0, skid_valid_q};

`ifdef EXWB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count edges where WB holds off a valid head; saturate instead of wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (head_valid_q && !out_ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Counter register; flush deliberately leaves it alone
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_exwb_skid_stage.sv
// tb_exwb_skid_stage: directed scoreboard bench for exwb_skid_stage.
// The driver queues the expected entry whenever a push is accepted. The monitor
// pops and compares the head whenever WB consumes it.
module tb_exwb_skid_stage;

  logic        clk = 1'b1;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_ctrl = '0;
  logic [31:0] in_mem = '0;
  logic [31:0] in_alu = '0;
  logic [5:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_ctrl;
  logic [31:0] out_mem;
  logic [31:0] out_alu;
  logic [5:0]  out_rd;
  logic [31:0] out_wbdata;
  logic        out_regwe;
  logic [1:0]  occupancy;
`ifdef EXWB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  exwb_skid_stage #(.DATA_W(32), .RD_W(6), .CTRL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_mem(in_mem), .in_alu(in_alu), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_mem(out_mem), .out_alu(out_alu), .out_rd(out_rd),
    .out_wbdata(out_wbdata), .out_regwe(out_regwe), .occupancy(occupancy)
`ifdef EXWB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Active edge is negedge; the monitor samples on posedge
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [5:0]  rd;
    logic [31:0] wb;
    logic        regwe;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Drive one cycle of inputs just after the active edge, then advance past the next one
  task automatic step(input logic v, input logic [7:0] c, input logic [31:0] m,
                      input logic [31:0] a, input logic [5:0] r, input logic [31:0] wb,
                      input logic we, input logic ordy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_mem    = m;
    in_alu    = a;
    in_rd     = r;
    out_ready = ordy;
    flush     = fl;
    if (fl) sb.delete();
    else if (v && in_ready) sb.push_back('{c, m, a, r, wb, we});
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input logic ordy, input logic fl);
    step(1'b0, 8'h00, 32'h0, 32'h0, 6'd0, 32'h0, 1'b0, ordy, fl);
  endtask

  // Scoreboard monitor: compare the head each time WB takes it
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got wbdata=%h rd=%0d, required no output", out_wbdata, out_rd);
      end else begin
        mon_e = sb.pop_front();
        if (out_wbdata !== mon_e.wb || out_regwe !== mon_e.regwe || out_rd !== mon_e.rd ||
            out_alu !== mon_e.alu || out_mem !== mon_e.mem || out_ctrl !== mon_e.ctrl) begin
          n_fail++;
          $display("FAIL head_out: got wb=%h we=%b rd=%0d alu=%h mem=%h ctrl=%h, required wb=%h we=%b rd=%0d alu=%h mem=%h ctrl=%h",
                   out_wbdata, out_regwe, out_rd, out_alu, out_mem, out_ctrl,
                   mon_e.wb, mon_e.regwe, mon_e.rd, mon_e.alu, mon_e.mem, mon_e.ctrl);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    // Power-on reset
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_regwe", 32'(out_regwe), 32'd0);
    chk("rst_alu", out_alu, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Streaming: back-to-back pushes with WB always ready
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 8'h08, 32'hDEAD_0000, 32'(k), 6'(k), 32'(k), 1'b1, 1'b1, 1'b0);
      chk("stream_wbdata", out_wbdata, 32'(k));
      chk("stream_occ", 32'(occupancy), 32'd1);
      chk("stream_regwe", 32'(out_regwe), 32'd1);
    end
    idle(1'b1, 1'b0);
    chk("stream_drain_occ", 32'(occupancy), 32'd0);

    // Stall: second entry lands in the skid slot, head holds
    step(1'b1, 8'h00, 32'h0, 32'hA, 6'd10, 32'hA, 1'b0, 1'b0, 1'b0);
    chk("stall_occ1", 32'(occupancy), 32'd1);
    step(1'b1, 8'h00, 32'h0, 32'hB, 6'd11, 32'hB, 1'b0, 1'b0, 1'b0);
    chk("stall_occ2", 32'(occupancy), 32'd2);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_head", out_wbdata, 32'hA);
    step(1'b1, 8'h00, 32'h0, 32'hC, 6'd12, 32'hC, 1'b0, 1'b0, 1'b0);
    chk("stall_hold_head", out_wbdata, 32'hA);
    chk("stall_hold_occ", 32'(occupancy), 32'd2);
    idle(1'b1, 1'b0);
    chk("release_head", out_wbdata, 32'hB);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_occ", 32'(occupancy), 32'd1);
    idle(1'b1, 1'b0);
    chk("release_drain_occ", 32'(occupancy), 32'd0);
    chk("empty_regwe", 32'(out_regwe), 32'd0);

    // Write-back mux and regwe
    step(1'b1, 8'h0C, 32'h55, 32'h77, 6'd3, 32'h55, 1'b1, 1'b0, 1'b0);
    chk("mux_mem_wb", out_wbdata, 32'h55);
    chk("mux_regwe1", 32'(out_regwe), 32'd1);
    step(1'b1, 8'h04, 32'h55, 32'h77, 6'd4, 32'h55, 1'b0, 1'b1, 1'b0);
    chk("mux_regwe0", 32'(out_regwe), 32'd0);
    chk("mux_mem_wb2", out_wbdata, 32'h55);
    step(1'b1, 8'h08, 32'h55, 32'h77, 6'd5, 32'h77, 1'b1, 1'b1, 1'b0);
    chk("mux_alu_wb", out_wbdata, 32'h77);
    idle(1'b1, 1'b0);

    // Flush with both slots full and an incoming push
    step(1'b1, 8'h08, 32'h0, 32'h100, 6'd1, 32'h100, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h08, 32'h0, 32'h200, 6'd2, 32'h200, 1'b1, 1'b0, 1'b0);
    chk("pre_flush_occ", 32'(occupancy), 32'd2);
    step(1'b1, 8'h08, 32'h0, 32'h300, 6'd3, 32'h300, 1'b1, 1'b1, 1'b1);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    // Flush with one slot full while in_ready=1: the incoming push is dropped too
    step(1'b1, 8'h08, 32'h0, 32'h400, 6'd4, 32'h400, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h08, 32'h0, 32'h500, 6'd5, 32'h500, 1'b1, 1'b0, 1'b1);
    chk("flush1_occ", 32'(occupancy), 32'd0);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);
    chk("flush_no_ghost", 32'(out_valid), 32'd0);

    // Asynchronous reset with both slots full, away from any clock edge
    step(1'b1, 8'h08, 32'h0, 32'h600, 6'd6, 32'h600, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h08, 32'h0, 32'h700, 6'd7, 32'h700, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_occ", 32'(occupancy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_regwe", 32'(out_regwe), 32'd0);
`ifdef EXWB_STALL_CNT_EN
    chk("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    sb.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    #2;
    step(1'b1, 8'h0C, 32'h99, 32'h11, 6'd9, 32'h99, 1'b1, 1'b1, 1'b0);
    chk("post_rst_wb", out_wbdata, 32'h99);
    idle(1'b1, 1'b0);

`ifdef EXWB_STALL_CNT_EN
    // Saturating stall counter, unaffected by flush
    step(1'b1, 8'h08, 32'h0, 32'hEE, 6'd1, 32'hEE, 1'b1, 1'b0, 1'b0);
    chk("stall_cnt_start", 32'(stall_cnt), 32'd0);
    idle(1'b0, 1'b0);
    chk("stall_cnt_one", 32'(stall_cnt), 32'd1);
    for (int i = 0; i < 65600; i++) idle(1'b0, 1'b0);
    chk("stall_cnt_sat", 32'(stall_cnt), 32'hFFFF);
    idle(1'b0, 1'b1);
    chk("stall_cnt_flush", 32'(stall_cnt), 32'hFFFF);
    chk("stall_flush_occ", 32'(occupancy), 32'd0);
`endif

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
